// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between I-cache refills and D-cache refills/stores,
// sequencing block refills word by word with round-robin arbitration on conflicts.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic [IDX_W-1:0]  ic_word_idx,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic [IDX_W-1:0]  dc_word_idx,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    typedef enum logic [2:0] {
        IDLE,
        IC_RD,
        DC_RD,
        DC_WR,
        DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  count;
    logic              last_dc;

    // Done pulses are raised on the edge entering DONE so they coincide with the last rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            last_dc     <= 1'b0;
            ic_rdata    <= '0;
            ic_rvalid   <= 1'b0;
            ic_word_idx <= '0;
            ic_done     <= 1'b0;
            dc_rdata    <= '0;
            dc_rvalid   <= 1'b0;
            dc_word_idx <= '0;
            dc_done     <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (ic_req && (!dc_req || last_dc)) begin
                        state    <= IC_RD;
                        last_dc  <= 1'b0;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ic_addr & BLOCK_MASK;
                        count    <= '0;
                    end else if (dc_req) begin
                        last_dc  <= 1'b1;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        count    <= '0;
                        if (dc_we) begin
                            state     <= DC_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= dc_wdata;
                            mem_addr  <= dc_addr & WORD_MASK;
                        end else begin
                            state    <= DC_RD;
                            mem_we   <= 1'b0;
                            mem_addr <= dc_addr & BLOCK_MASK;
                        end
                    end
                end

                IC_RD: begin
                    if (mem_ready) begin
                        ic_rdata    <= mem_rdata;
                        ic_rvalid   <= 1'b1;
                        ic_word_idx <= count;
                        if (count == LAST_IDX) begin
                            mem_req <= 1'b0;
                            ic_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            count    <= count + IDX_W'(1);
                            mem_addr <= mem_addr + WORD_STEP;
                        end
                    end
                end

                DC_RD: begin
                    if (mem_ready) begin
                        dc_rdata    <= mem_rdata;
                        dc_rvalid   <= 1'b1;
                        dc_word_idx <= count;
                        if (count == LAST_IDX) begin
                            mem_req <= 1'b0;
                            dc_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            count    <= count + IDX_W'(1);
                            mem_addr <= mem_addr + WORD_STEP;
                        end
                    end
                end

                DC_WR: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        dc_done <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected words/writes/dones,
// a posedge monitor and a memory responder pop and compare whatever the DUT presents.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BW     = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_rvalid;
    logic [IDX_W-1:0]  ic_word_idx;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_rvalid;
    logic [IDX_W-1:0]  dc_word_idx;
    logic              dc_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
        .ic_word_idx(ic_word_idx), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_word_idx(dc_word_idx), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    word_t ic_words[$];
    word_t dc_words[$];
    bit    ic_dones[$];
    bit    dc_dones[$];
    wr_t   wr_q[$];
    int    done_order[$];
    bit    ready_pat[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ready_mode = 0;
    int model_last = 0;
    bit prev_done  = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One complete requester transaction; called at a negedge, returns at a negedge.
    task automatic applyStimulus(input bit owner_dc, input bit we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        logic [ADDR_W-1:0] base;
        int waited;
        bit seen;
        if (owner_dc && we) begin
            wr_q.push_back('{addr: addr - (addr % 4), data: wdata});
            dc_dones.push_back(1'b0);
        end else begin
            base = addr - (addr % (BW * 4));
            for (int i = 0; i < BW; i++) begin
                if (owner_dc) dc_words.push_back('{idx: IDX_W'(i), data: base + ADDR_W'(4 * i)});
                else          ic_words.push_back('{idx: IDX_W'(i), data: base + ADDR_W'(4 * i)});
            end
            if (owner_dc) dc_dones.push_back(1'b1);
            else          ic_dones.push_back(1'b1);
        end
        if (owner_dc) begin
            dc_addr = addr; dc_we = we; dc_wdata = wdata; dc_req = 1'b1;
        end else begin
            ic_addr = addr; ic_req = 1'b1;
        end
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            waited++;
            seen = owner_dc ? dc_done : ic_done;
        end
        checkOutput(owner_dc ? "dc_done_seen" : "ic_done_seen", 64'(seen), 64'd1);
        if (owner_dc) dc_req = 1'b0;
        else          ic_req = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        ic_req = 1'b0;
        dc_req = 1'b0;
        repeat (3) @(negedge clk);
        ic_words.delete(); dc_words.delete(); ic_dones.delete(); dc_dones.delete(); wr_q.delete();
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_ic_rvalid", 64'(ic_rvalid), 64'd0);
        checkOutput("reset_dc_rvalid", 64'(dc_rvalid), 64'd0);
        checkOutput("reset_ic_done", 64'(ic_done), 64'd0);
        checkOutput("reset_dc_done", 64'(dc_done), 64'd0);
        checkOutput("reset_ic_rdata", 64'(ic_rdata), 64'd0);
        checkOutput("reset_dc_rdata", 64'(dc_rdata), 64'd0);
        rst = 1'b0;
        model_last = 0;
    endtask

    // Output monitor: every rvalid/done the DUT presents is matched against the scoreboard.
    initial begin
        word_t w;
        bit    fl;
        forever begin
            @(posedge clk);
            #1;
            if (ic_rvalid) begin
                checkOutput("ic_rvalid_expected", 64'(ic_words.size() != 0), 64'd1);
                if (ic_words.size() != 0) begin
                    w = ic_words.pop_front();
                    checkOutput("ic_word_idx", 64'(ic_word_idx), 64'(w.idx));
                    checkOutput("ic_rdata", 64'(ic_rdata), 64'(w.data));
                end
            end
            if (dc_rvalid) begin
                checkOutput("dc_rvalid_expected", 64'(dc_words.size() != 0), 64'd1);
                if (dc_words.size() != 0) begin
                    w = dc_words.pop_front();
                    checkOutput("dc_word_idx", 64'(dc_word_idx), 64'(w.idx));
                    checkOutput("dc_rdata", 64'(dc_rdata), 64'(w.data));
                end
            end
            if (ic_rvalid || dc_rvalid)
                checkOutput("rvalid_one_owner", 64'(ic_rvalid & dc_rvalid), 64'd0);
            if (ic_done) begin
                checkOutput("ic_done_expected", 64'(ic_dones.size() != 0), 64'd1);
                if (ic_dones.size() != 0) begin
                    fl = ic_dones.pop_front();
                    checkOutput("ic_done_with_last_word", 64'(ic_rvalid), 64'(fl));
                end
                checkOutput("ic_words_left_at_done", 64'(ic_words.size()), 64'd0);
                done_order.push_back(0);
            end
            if (dc_done) begin
                checkOutput("dc_done_expected", 64'(dc_dones.size() != 0), 64'd1);
                if (dc_dones.size() != 0) begin
                    fl = dc_dones.pop_front();
                    checkOutput("dc_done_with_last_word", 64'(dc_rvalid), 64'(fl));
                end
                checkOutput("dc_words_left_at_done", 64'(dc_words.size()), 64'd0);
                done_order.push_back(1);
            end
            if (ic_done || dc_done)
                checkOutput("done_one_owner", 64'(ic_done & dc_done), 64'd0);
            if (mem_req || ic_done || dc_done)
                checkOutput("busy_active", 64'(busy), 64'd1);
            if (prev_done)
                checkOutput("busy_after_done", 64'(busy), 64'd0);
            prev_done = ic_done | dc_done;
        end
    end

    // Memory responder: data equals address, checks writes and stall stability.
    initial begin
        bit r;
        bit rst_edge;
        bit stall_pending = 1'b0;
        logic              held_we;
        logic [ADDR_W-1:0] held_addr;
        logic [DATA_W-1:0] held_wdata;
        wr_t wexp;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            @(negedge clk);
            if (stall_pending && !rst_edge) begin
                checkOutput("stall_mem_req", 64'(mem_req), 64'd1);
                checkOutput("stall_mem_we", 64'(mem_we), 64'(held_we));
                checkOutput("stall_mem_addr", 64'(mem_addr), 64'(held_addr));
                if (held_we) checkOutput("stall_mem_wdata", 64'(mem_wdata), 64'(held_wdata));
            end
            if (mem_req === 1'b1) begin
                if (ready_pat.size() != 0) r = ready_pat.pop_front();
                else if (ready_mode == 1)  r = ($urandom_range(0, 3) != 0);
                else                       r = 1'b1;
            end else begin
                r = 1'($urandom_range(0, 1));
            end
            mem_ready = r;
            mem_rdata = (mem_req === 1'b1) ? mem_addr : $urandom;
            if (mem_req === 1'b1 && mem_we === 1'b1 && r) begin
                checkOutput("mem_write_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    wexp = wr_q.pop_front();
                    checkOutput("mem_write_addr", 64'(mem_addr), 64'(wexp.addr));
                    checkOutput("mem_write_data", 64'(mem_wdata), 64'(wexp.data));
                end
            end
            stall_pending = (mem_req === 1'b1) && !r;
            held_we    = mem_we;
            held_addr  = mem_addr;
            held_wdata = mem_wdata;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] a0, a1;
        int first_exp;
        int waited;
        bit seen;

        rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        @(negedge clk);
        doReset();

        $display("[TB] IC refill alone");
        applyStimulus(1'b0, 1'b0, 32'h0000_104C, 32'h0);
        model_last = 0;

        $display("[TB] DC store with two wait states");
        ready_pat = '{1'b0, 1'b0, 1'b1};
        applyStimulus(1'b1, 1'b1, 32'h0000_2003, 32'hDEAD_BEEF);
        model_last = 1;

        $display("[TB] simultaneous requests after reset");
        doReset();
        for (int pair = 0; pair < 2; pair++) begin
            a0 = $urandom;
            a1 = $urandom;
            first_exp = (model_last == 0) ? 1 : 0;
            done_order.delete();
            fork
                applyStimulus(1'b0, 1'b0, a0, 32'h0);
                applyStimulus(1'b1, 1'b0, a1, 32'h0);
            join
            checkOutput("conflict_done_count", 64'(done_order.size()), 64'd2);
            if (done_order.size() != 0)
                checkOutput("conflict_first_owner", 64'(done_order[0]), 64'(first_exp));
            model_last = 1 - first_exp;
            if (pair == 0) begin
                applyStimulus(1'b1, 1'b1, $urandom, $urandom);
                model_last = 1;
            end
        end

        $display("[TB] DC refill with ready stalls");
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(1'b1, 1'b0, 32'h0000_3A18, 32'h0);

        $display("[TB] reset in the middle of an IC refill");
        ic_words.delete(); ic_dones.delete();
        for (int i = 0; i < BW; i++) ic_words.push_back('{idx: IDX_W'(i), data: 32'h5000 + 32'(4 * i)});
        ic_dones.push_back(1'b1);
        ic_addr = 32'h0000_5008;
        ic_req = 1'b1;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            seen = ic_rvalid && (ic_word_idx == IDX_W'(1));
        end
        checkOutput("midreset_word1_seen", 64'(seen), 64'd1);
        rst = 1'b1;
        ic_req = 1'b0;
        ic_words.delete();
        ic_dones.delete();
        @(posedge clk);
        #1;
        checkOutput("midreset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_ic_done", 64'(ic_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_last = 0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_6004, 32'h0);

        $display("[TB] block at top of address space");
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF4, 32'h0);

        $display("[TB] random traffic with random stalls");
        ready_mode = 1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(1'b0, 1'b0, $urandom, 32'h0);
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
        join
        repeat (4) @(negedge clk);

        checkOutput("ic_words_drained", 64'(ic_words.size()), 64'd0);
        checkOutput("dc_words_drained", 64'(dc_words.size()), 64'd0);
        checkOutput("writes_drained", 64'(wr_q.size()), 64'd0);
        checkOutput("final_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
